// File: rtl/isa_dma_arbiter.sv
// rtl/isa_dma_arbiter.sv - round-robin ISA DMA arbiter for the low (0-3) and high (5-7) DRQ banks
module isa_dma_arbiter #(
    parameter int NREQ        = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   req_chan,
    input  logic [7:0]          dack_n,
    input  logic                ior_n,
    input  logic                iow_n,
    input  logic                aen,
    input  logic                tc,
    input  logic [15:0]         sd,
    output logic [2:0]          drq_lo_sel,
    output logic                drq_lo_trig_n,
    output logic [2:0]          drq_hi_sel,
    output logic                drq_hi_trig_n,
    output logic [NREQ-1:0]     ack,
    output logic                ack_write,
    output logic                ack_tc,
    output logic [15:0]         dma_data,
    output logic [NREQ-1:0]     bad_chan
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [27:0] SYNC_RST = {16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF};

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_XFER, S_GAP} state_t;

    logic [27:0] sync_q [SYNC_STAGES];
    logic [27:0] sync_out;
    logic [7:0]  dack_s;
    logic        ior_s, iow_s, aen_s, tc_s;
    logic [15:0] sd_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= SYNC_RST;
        end else begin
            sync_q[0] <= {sd, tc, aen, iow_n, ior_n, dack_n};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign dack_s   = sync_out[7:0];
    assign ior_s    = sync_out[8];
    assign iow_s    = sync_out[9];
    assign aen_s    = sync_out[10];
    assign tc_s     = sync_out[11];
    assign sd_s     = sync_out[27:12];

    logic [2:0]      rchan [NREQ];
    logic [NREQ-1:0] cand  [2];

    // Channel 4 is the cascade channel: it belongs to neither bank.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rchan[i]   = req_chan[3*i +: 3];
            cand[0][i] = req[i] & ~rchan[i][2];
            cand[1][i] = req[i] & rchan[i][2] & (rchan[i][1:0] != 2'b00);
        end
    end

    // Index 0 is the low bank, index 1 the high bank.
    state_t        state_q [2], state_d [2];
    logic [PW-1:0] grant_q [2], grant_d [2];
    logic [PW-1:0] ptr_q   [2], ptr_d   [2];
    logic [2:0]    chan_q  [2], chan_d  [2];
    logic          dir_q   [2], dir_d   [2];
    logic          tcf_q   [2], tcf_d   [2];
    logic [15:0]   dbuf_q  [2], dbuf_d  [2];
    logic [CW-1:0] cnt_q   [2], cnt_d   [2];
    logic [1:0]    fin;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!rst_n) begin
                state_q[b] <= S_IDLE;
                grant_q[b] <= '0;
                ptr_q[b]   <= '0;
                chan_q[b]  <= '0;
                dir_q[b]   <= 1'b0;
                tcf_q[b]   <= 1'b0;
                dbuf_q[b]  <= '0;
                cnt_q[b]   <= '0;
            end else begin
                state_q[b] <= state_d[b];
                grant_q[b] <= grant_d[b];
                ptr_q[b]   <= ptr_d[b];
                chan_q[b]  <= chan_d[b];
                dir_q[b]   <= dir_d[b];
                tcf_q[b]   <= tcf_d[b];
                dbuf_q[b]  <= dbuf_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
        end
    end

    always_comb begin
        logic found;
        logic strobe_lo;
        int   j;
        fin       = '0;
        found     = 1'b0;
        strobe_lo = 1'b0;
        j         = 0;
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            grant_d[b] = grant_q[b];
            ptr_d[b]   = ptr_q[b];
            chan_d[b]  = chan_q[b];
            dir_d[b]   = dir_q[b];
            tcf_d[b]   = tcf_q[b];
            dbuf_d[b]  = dbuf_q[b];
            cnt_d[b]   = cnt_q[b];
            found      = 1'b0;
            strobe_lo  = dir_q[b] ? ~iow_s : ~ior_s;
            unique case (state_q[b])
                S_IDLE: begin
                    for (int k = 0; k < NREQ; k++) begin
                        j = int'(ptr_q[b]) + k;
                        if (j >= NREQ) j = j - NREQ;
                        if (!found && cand[b][j]) begin
                            found      = 1'b1;
                            grant_d[b] = PW'(j);
                            chan_d[b]  = rchan[j];
                        end
                    end
                    if (found) state_d[b] = S_SETUP;
                end
                S_SETUP: state_d[b] = S_REQ;
                S_REQ: begin
                    if (!req[grant_q[b]]) begin
                        state_d[b] = S_IDLE;
                    end else if (!dack_s[chan_q[b]] && aen_s && (!ior_s || !iow_s)) begin
                        state_d[b] = S_XFER;
                        dir_d[b]   = ~iow_s;
                        dbuf_d[b]  = sd_s;
                        tcf_d[b]   = tc_s;
                    end
                end
                S_XFER: begin
                    if (strobe_lo && !dack_s[chan_q[b]]) begin
                        dbuf_d[b] = sd_s;
                        tcf_d[b]  = tcf_q[b] | tc_s;
                    end else begin
                        fin[b]     = 1'b1;
                        ptr_d[b]   = (grant_q[b] == PW'(NREQ-1)) ? '0 : grant_q[b] + 1'b1;
                        cnt_d[b]   = '0;
                        state_d[b] = S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_q[b] == CW'(GAP_CYCLES-1)) state_d[b] = S_IDLE;
                    else cnt_d[b] = cnt_q[b] + 1'b1;
                end
                default: state_d[b] = S_IDLE;
            endcase
        end
    end

    assign drq_lo_sel    = chan_q[0];
    assign drq_hi_sel    = chan_q[1];
    assign drq_lo_trig_n = (state_q[0] != S_REQ);
    assign drq_hi_trig_n = (state_q[1] != S_REQ);

    // On coincident completions the high bank's qualifiers take precedence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack       <= '0;
            ack_write <= 1'b0;
            ack_tc    <= 1'b0;
            dma_data  <= '0;
            bad_chan  <= '0;
        end else begin
            ack <= '0;
            for (int b = 0; b < 2; b++) begin
                if (fin[b]) ack[grant_q[b]] <= 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                bad_chan[i] <= req[i] & (rchan[i] == 3'd4);
            end
            if (fin[1]) begin
                ack_write <= dir_q[1];
                ack_tc    <= tcf_q[1];
                dma_data  <= dbuf_q[1];
            end else if (fin[0]) begin
                ack_write <= dir_q[0];
                ack_tc    <= tcf_q[0];
                dma_data  <= dbuf_q[0];
            end
        end
    end
endmodule

// File: tb/tb_isa_dma_arbiter.sv
// tb/tb_isa_dma_arbiter.sv - directed self-checking bench for isa_dma_arbiter
module tb_isa_dma_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] req_chan;
    logic [7:0]  dack_n;
    logic        ior_n, iow_n, aen, tc;
    logic [15:0] sd;
    logic [2:0]  drq_lo_sel, drq_hi_sel;
    logic        drq_lo_trig_n, drq_hi_trig_n;
    logic [3:0]  ack;
    logic        ack_write, ack_tc;
    logic [15:0] dma_data;
    logic [3:0]  bad_chan;

    int compares = 0;
    int fails    = 0;
    int pulses   = 0;
    int snap;
    bit ok;

    isa_dma_arbiter #(.NREQ(4), .GAP_CYCLES(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_chan(req_chan),
        .dack_n(dack_n), .ior_n(ior_n), .iow_n(iow_n), .aen(aen), .tc(tc), .sd(sd),
        .drq_lo_sel(drq_lo_sel), .drq_lo_trig_n(drq_lo_trig_n),
        .drq_hi_sel(drq_hi_sel), .drq_hi_trig_n(drq_hi_trig_n),
        .ack(ack), .ack_write(ack_write), .ack_tc(ack_tc),
        .dma_data(dma_data), .bad_chan(bad_chan)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ack != 4'b0000) pulses++;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pins_idle();
        dack_n = 8'hFF; ior_n = 1'b1; iow_n = 1'b1; aen = 1'b0; tc = 1'b0; sd = 16'h0000;
    endtask

    task automatic pins_set(input logic [7:0] dk, input bit wr, input logic [15:0] d, input bit t);
        dack_n = dk; aen = 1'b1; ior_n = wr; iow_n = ~wr; sd = d; tc = t;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0000; req_chan = 12'h000; pins_idle();
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_trig(input bit hi, output bit found);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if ((hi ? drq_hi_trig_n : drq_lo_trig_n) == 1'b0) found = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_trig_high(input bit hi, output bit found);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if ((hi ? drq_hi_trig_n : drq_lo_trig_n) == 1'b1) found = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_ack(output bit found);
        found = 1'b0;
        for (int n = 0; n < 16 && !found; n++) begin
            tick();
            if (ack != 4'b0000) found = 1'b1;
        end
    endtask

    task automatic xfer(input logic [2:0] ch, input bit wr, input logic [15:0] d, input bit t);
        pins_set(~(8'h01 << ch), wr, d, t);
        tick(4);
        pins_idle();
    endtask

    logic [2:0] exp_sel [4];
    logic [3:0] exp_ack [4];

    initial begin
        exp_sel = '{3'd1, 3'd3, 3'd1, 3'd3};
        exp_ack = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};

        // reset state
        do_reset();
        check("rst_lo_sel", drq_lo_sel, 0);
        check("rst_hi_sel", drq_hi_sel, 0);
        check("rst_trig", {drq_lo_trig_n, drq_hi_trig_n}, 2'b11);
        check("rst_ack", {ack, ack_write, ack_tc}, 0);
        check("rst_data", dma_data, 0);
        check("rst_bad", bad_chan, 0);

        // single write transfer on channel 1, exact timing
        req_chan = 12'o0001; req = 4'b0001;
        tick();
        check("t1_sel_setup", drq_lo_sel, 1);
        check("t1_trig_setup", drq_lo_trig_n, 1);
        tick();
        check("t1_trig_req", drq_lo_trig_n, 0);
        pins_set(~8'h02, 1'b1, 16'hA55A, 1'b1);
        tick(2);
        check("t1_trig_sync", drq_lo_trig_n, 0);
        tick();
        check("t1_trig_xfer", drq_lo_trig_n, 1);
        snap = pulses;
        tick();
        pins_idle(); req = 4'b0000;
        tick(2);
        check("t1_no_early_ack", ack, 0);
        tick();
        check("t1_ack", ack, 4'b0001);
        check("t1_data", dma_data, 16'hA55A);
        check("t1_write_tc", {ack_write, ack_tc}, 2'b11);
        tick();
        check("t1_ack_clear", ack, 0);
        check("t1_gap_trig", drq_lo_trig_n, 1);
        check("t1_data_held", dma_data, 16'hA55A);
        tick();
        check("t1_gap_trig2", drq_lo_trig_n, 1);
        check("t1_one_pulse", pulses - snap, 1);

        // round robin between requesters 0 (ch1) and 1 (ch3)
        do_reset();
        req_chan = 12'o0031; req = 4'b0011;
        for (int n = 0; n < 4; n++) begin
            wait_trig(1'b0, ok);
            check("rr_trig", ok, 1);
            check("rr_sel", drq_lo_sel, exp_sel[n]);
            xfer(exp_sel[n], 1'b0, 16'h1000 + 16'(n), 1'b0);
            wait_ack(ok);
            check("rr_ack_seen", ok, 1);
            check("rr_ack", ack, exp_ack[n]);
            check("rr_data", {ack_write, dma_data}, {1'b0, 16'h1000 + 16'(n)});
        end

        // both banks concurrently, coincident completion
        do_reset();
        req_chan = 12'o0501; req = 4'b0101;
        tick(2);
        check("dual_trig", {drq_lo_trig_n, drq_hi_trig_n}, 2'b00);
        check("dual_sel", {drq_lo_sel, drq_hi_sel}, {3'd1, 3'd5});
        pins_set(~8'h20, 1'b0, 16'h5555, 1'b1);
        tick(4);
        check("dual_hi_xfer", {drq_lo_trig_n, drq_hi_trig_n}, 2'b01);
        dack_n = ~8'h22; iow_n = 1'b0; tc = 1'b0; sd = 16'h1111;
        tick(4);
        check("dual_lo_xfer", drq_lo_trig_n, 1);
        pins_idle(); req = 4'b0000;
        wait_ack(ok);
        check("dual_ack_seen", ok, 1);
        check("dual_ack", ack, 4'b0101);
        check("dual_hi_wins", {ack_write, ack_tc, dma_data}, {1'b0, 1'b1, 16'h1111});

        // request dropped in REQ, then dropped during XFER
        do_reset();
        req_chan = 12'o0021; req = 4'b0001;
        wait_trig(1'b0, ok);
        check("drop_trig", ok, 1);
        snap = pulses;
        req = 4'b0000;
        tick();
        check("drop_trig_high", drq_lo_trig_n, 1);
        tick(6);
        check("drop_no_ack", pulses - snap, 0);
        req = 4'b0010;
        wait_trig(1'b0, ok);
        check("rearb_trig", ok, 1);
        check("rearb_sel", drq_lo_sel, 2);
        pins_set(~8'h04, 1'b1, 16'hBEEF, 1'b0);
        wait_trig_high(1'b0, ok);
        check("late_xfer", ok, 1);
        req = 4'b0000;
        tick(2);
        pins_idle();
        wait_ack(ok);
        check("late_ack_seen", ok, 1);
        check("late_ack", {ack, ack_write, dma_data}, {4'b0010, 1'b1, 16'hBEEF});

        // channel 4 is never granted; others still served
        req_chan = 12'o4001; req = 4'b1000;
        tick();
        check("bad_flag", bad_chan, 4'b1000);
        snap = pulses;
        tick(6);
        check("bad_no_trig", {drq_lo_trig_n, drq_hi_trig_n}, 2'b11);
        check("bad_no_ack", pulses - snap, 0);
        req = 4'b1001;
        wait_trig(1'b0, ok);
        check("bad_other_trig", ok, 1);
        check("bad_other_sel", drq_lo_sel, 1);
        xfer(3'd1, 1'b0, 16'h0F0F, 1'b0);
        wait_ack(ok);
        check("bad_other_ack", {ok, ack, dma_data}, {1'b1, 4'b0001, 16'h0F0F});
        check("bad_flag_held", bad_chan, 4'b1000);
        req = 4'b0000;
        tick(6);

        // reset in the middle of a transfer
        req_chan = 12'o0060; req = 4'b0010;
        wait_trig(1'b1, ok);
        check("rx_trig", ok, 1);
        check("rx_sel", drq_hi_sel, 6);
        pins_set(~8'h40, 1'b0, 16'hDEAD, 1'b0);
        wait_trig_high(1'b1, ok);
        check("rx_xfer", ok, 1);
        snap = pulses;
        rst_n = 1'b0; req = 4'b0000; pins_idle();
        tick();
        check("rx_sel_rst", {drq_lo_sel, drq_hi_sel}, 0);
        check("rx_trig_rst", {drq_lo_trig_n, drq_hi_trig_n}, 2'b11);
        check("rx_out_rst", {ack, ack_write, ack_tc, dma_data, bad_chan}, 0);
        rst_n = 1'b1;
        tick(6);
        check("rx_no_ack", pulses - snap, 0);
        req_chan = 12'o3002; req = 4'b1001;
        wait_trig(1'b0, ok);
        check("rx_fresh_trig", ok, 1);
        check("rx_fresh_sel", drq_lo_sel, 2);
        xfer(3'd2, 1'b0, 16'h7E57, 1'b0);
        wait_ack(ok);
        check("rx_fresh_ack", {ok, ack}, {1'b1, 4'b0001});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
